camera_stream_tx: RTL
=====================

# camera_stream_tx

Frame-buffer-to-DVP pixel stream transmitter. It reads RGB565 pixels from a single-port synchronous RAM and drives an OV7670-style parallel camera bus (vsync, href, 8-bit data, high byte first). The bus pins are clocked on p_clock. It is the source-side counterpart of the camera capture path: it feeds recorded or synthetic frames into the capture logic for bring-up and loopback tests, with no sensor attached.

## Interface
- H_ACTIVE, 320, pixels per line.
- V_ACTIVE, 240, lines per frame.
- HBLANK, 16, href-low cycles after each line's active bytes (must be ≥2).
- VS_CYCLES, 8, cycles vsync is high at frame start (must be ≥1).
- VBP_CYCLES, 20, cycles between vsync fall and first href (must be ≥2).
- VFP_CYCLES, 20, cycles after the last line's blank before the next vsync or idle (must be ≥1).
- p_clock  in  1  sole clock; all outputs registered on its rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  level; start or continue streaming frames.
- rd_addr  out  17  frame-buffer read address, pixel index y*H_ACTIVE+x.
- mem_data  in  16  RAM read data; valid on the 2nd rising edge after rd_addr changes.
- vsync  out  1  high = vertical sync / idle.
- href  out  1  high while p_data carries active bytes.
- p_data  out  8  pixel byte; 0 whenever href is low.
- frame_done  out  1  one-cycle pulse on the last VFP cycle of each frame.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, VSYNC, VBP, ACTIVE, HBL, VFP.
- Reset values: state IDLE, vsync=1, href=0, p_data=0, rd_addr=0, frame_done=0, busy=0, all counters 0.
- IDLE: vsync=1. If enable=1, go to VSYNC.
- VSYNC: vsync=1 for VS_CYCLES cycles, then VBP.
- VBP: vsync=0 for VBP_CYCLES cycles, then ACTIVE for line 0.
- ACTIVE: href=1 for 2*H_ACTIVE cycles. The even cycle of each pixel carries mem_data[15:8]; the odd cycle carries the latched [7:0]. Then HBL.
- HBL: href=0 for HBLANK cycles. Then ACTIVE for the next line, or VFP after line V_ACTIVE-1.
- VFP: vsync=0 for VFP_CYCLES cycles, with frame_done=1 on the last one. Then VSYNC if enable=1, else IDLE.
- Read pipeline:
  - rd_addr for pixel k is issued 2 cycles before its high byte appears.
  - The first pixel of each line is addressed from the last 2 cycles of VBP or HBL.
  - On the edge that presents the high byte, mem_data is latched into a 16-bit pixel register and rd_addr advances by 1.
  - After the last pixel of the frame (V_ACTIVE*H_ACTIVE-1), rd_addr wraps to 0 and holds there until the next frame's prefetch.
- Addresses are contiguous across lines: line y starts at y*H_ACTIVE and there is no per-line reset. rd_addr is 17 bits; V_ACTIVE*H_ACTIVE must be ≤ 131072.
- Frame length in cycles: VS_CYCLES + VBP_CYCLES + V_ACTIVE*(2*H_ACTIVE+HBLANK) + VFP_CYCLES.
- enable deasserted mid-frame: the current frame completes in full, then the block goes to IDLE. Asserting enable again in IDLE starts a new frame from address 0.
- enable asserted while busy: no effect.
- reset mid-frame: takes effect on the next edge; all outputs return to reset values and no partial frame is resumed.

## Timing
- enable high sampled in IDLE at edge E: state becomes VSYNC at E; vsync stays 1, and its first low cycle follows VS_CYCLES cycles later.
- href rises exactly VBP_CYCLES cycles after vsync falls. href is never high while vsync is high.
- href and p_data change on the same edge; p_data holds each byte for exactly 1 cycle.
- Consecutive active lines are separated by exactly HBLANK href-low cycles.
- frame_done and the transition into VSYNC/IDLE: frame_done is high on the last VFP cycle. On the next edge frame_done returns to 0 and vsync goes to 1 (state VSYNC or IDLE).
- Continuous mode: back-to-back frames with no extra idle cycles.

## Test plan
- Frame shape: parameters H_ACTIVE=4, V_ACTIVE=2, HBLANK=3, VS_CYCLES=2, VBP_CYCLES=3, VFP_CYCLES=2, enable held 1.
  - Frame period is 29 cycles.
  - vsync high for 2 cycles, href pulses exactly 8 cycles long with a 3-cycle gap.
  - frame_done pulses once per 29 cycles.
- Byte order: RAM model returns 16'hA000+addr with 1-cycle latency.
  - p_data sequence line 0 = A0,00,A0,01,A0,02,A0,03; line 1 = A0,04,…,A0,07.
  - rd_addr runs 0..7, then wraps to 0.
- Single frame: pulse enable for 1 cycle in IDLE.
  - Exactly one frame is emitted, then IDLE with vsync=1 and busy=0.
  - rd_addr=0 after completion.
- Stop request: drop enable midway through line 0.
  - Line 1 and VFP still complete and frame_done pulses.
  - The block then goes to IDLE; no second vsync pulse occurs.
- Mid-frame reset: assert reset during an ACTIVE cycle.
  - Next cycle: href=0, p_data=0, vsync=1, rd_addr=0, busy=0.
  - Re-enabling produces a full frame starting at address 0.
- Loopback with the capture block: 320×240 defaults, ramp pattern.
  - The capture block reports frame_done once per frame.
  - The capture block's 76800 received pixels match the RAM contents in order.

Source files
------------

// File: rtl/camera_stream_tx_if.sv
// Parallel camera bus plus frame-buffer read port of the DVP stream transmitter.
interface camera_stream_tx_if;
  logic        enable;
  logic [16:0] rd_addr;
  logic [15:0] mem_data;
  logic        vsync;
  logic        href;
  logic [7:0]  p_data;
  logic        frame_done;
  logic        busy;

  modport master (
    input  enable, mem_data,
    output rd_addr, vsync, href, p_data, frame_done, busy
  );

  modport slave (
    output enable, mem_data,
    input  rd_addr, vsync, href, p_data, frame_done, busy
  );
endinterface

// File: rtl/camera_stream_tx.sv
// Frame-buffer to OV7670-style DVP transmitter: RGB565 pixels sent high byte first,
// read from a 2-cycle-latency RAM with the address running one pixel ahead.
module camera_stream_tx #(
  parameter int unsigned H_ACTIVE   = 320,
  parameter int unsigned V_ACTIVE   = 240,
  parameter int unsigned HBLANK     = 16,
  parameter int unsigned VS_CYCLES  = 8,
  parameter int unsigned VBP_CYCLES = 20,
  parameter int unsigned VFP_CYCLES = 20
) (
  input  logic                      p_clock,
  input  logic                      reset,
  camera_stream_tx_if.master        bus
);

  localparam int unsigned ADDR_W    = 17;
  localparam int unsigned LAST_ADDR = H_ACTIVE * V_ACTIVE - 1;
  localparam int unsigned LINE_LEN  = 2 * H_ACTIVE;
  localparam int unsigned MAX_A     = (VS_CYCLES > VBP_CYCLES) ? VS_CYCLES : VBP_CYCLES;
  localparam int unsigned MAX_B     = (LINE_LEN > HBLANK) ? LINE_LEN : HBLANK;
  localparam int unsigned MAX_C     = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_MAX   = (MAX_C > VFP_CYCLES) ? MAX_C : VFP_CYCLES;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam int unsigned LINE_W    = $clog2(V_ACTIVE + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBP    = 3'd2,
    ACTIVE = 3'd3,
    HBL    = 3'd4,
    VFP    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [7:0]          lo_q, lo_d;
  logic [7:0]          p_data_q, p_data_d;
  logic                vsync_q, vsync_d;
  logic                href_q, href_d;
  logic                frame_done_q, frame_done_d;
  logic                busy_q, busy_d;

  // State, counters and every bus output are registered together.
  always_ff @(posedge p_clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      line_q       <= '0;
      rd_addr_q    <= '0;
      lo_q         <= '0;
      p_data_q     <= '0;
      vsync_q      <= 1'b1;
      href_q       <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      line_q       <= line_d;
      rd_addr_q    <= rd_addr_d;
      lo_q         <= lo_d;
      p_data_q     <= p_data_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    line_d    = line_q;
    rd_addr_d = rd_addr_q;
    lo_d      = lo_q;
    p_data_d  = 8'h00;

    case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d = VSYNC;
          cnt_d   = '0;
        end
      end
      VSYNC: begin
        if (cnt_q == CNT_W'(VS_CYCLES - 1)) begin
          state_d = VBP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      VBP: begin
        if (cnt_q == CNT_W'(VBP_CYCLES - 1)) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ACTIVE: begin
        if (cnt_q == CNT_W'(LINE_LEN - 1)) begin
          state_d = HBL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HBL: begin
        if (cnt_q == CNT_W'(HBLANK - 1)) begin
          cnt_d = '0;
          if (line_q == LINE_W'(V_ACTIVE - 1)) begin
            state_d = VFP;
            line_d  = '0;
          end else begin
            state_d = ACTIVE;
            line_d  = line_q + LINE_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      VFP: begin
        if (cnt_q == CNT_W'(VFP_CYCLES - 1)) begin
          state_d = bus.enable ? VSYNC : IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        line_d  = '0;
      end
    endcase

    // High-byte edge latches the RAM word and issues the next pixel's address.
    if (state_d == ACTIVE) begin
      if (!cnt_d[0]) begin
        p_data_d  = bus.mem_data[15:8];
        lo_d      = bus.mem_data[7:0];
        rd_addr_d = (rd_addr_q == ADDR_W'(LAST_ADDR)) ? '0 : rd_addr_q + ADDR_W'(1);
      end else begin
        p_data_d = lo_q;
      end
    end

    vsync_d      = (state_d == IDLE) || (state_d == VSYNC);
    href_d       = (state_d == ACTIVE);
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == VFP) && (cnt_d == CNT_W'(VFP_CYCLES - 1));
  end

  assign bus.rd_addr    = rd_addr_q;
  assign bus.p_data     = p_data_q;
  assign bus.vsync      = vsync_q;
  assign bus.href       = href_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = busy_q;

endmodule
